// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - core load/store sequencer onto a word-wide memory port with sub-word RMW
// Byte/half support is built only when LSU_SUBWORD_EN is defined; otherwise only aligned words are legal.
module mem_access_unit #(
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_we_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  output logic        resp_valid_out,
  output logic [31:0] resp_rdata_out,
  output logic        resp_err_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wr_data_out,
  output logic        mem_we_out,
  input  logic [31:0] mem_rd_data_in
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_we;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  assign w_accept      = req_valid_in && (r_state == S_IDLE);
  assign req_ready_out = (r_state == S_IDLE);

`ifdef LSU_SUBWORD_EN
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_req_err = (req_size_in == 2'b11)
                  || ((req_size_in == 2'b01) && req_addr_in[0])
                  || ((req_size_in == 2'b10) && (req_addr_in[1:0] != 2'b00));

  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_size     <= req_size_in;
      r_unsigned <= req_unsigned_in;
      r_lane     <= req_addr_in[1:0];
      r_wdata    <= req_wdata_in;
    end
  end

  // Lane pick for loads and lane overwrite for RMW stores; word size passes straight through.
  always_comb begin
    w_byte       = mem_rd_data_in[{r_lane, 3'b000} +: 8];
    w_half       = mem_rd_data_in[{r_lane[1], 4'b0000} +: 16];
    w_load_data  = mem_rd_data_in;
    w_merge_data = mem_rd_data_in;
    case (r_size)
      2'b00: begin
        w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
        w_merge_data[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
        w_merge_data[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: begin
        w_load_data  = mem_rd_data_in;
        w_merge_data = r_wdata;
      end
    endcase
  end
`else
  logic w_unused_unsigned;

  assign w_unused_unsigned = req_unsigned_in;
  assign w_req_err    = (req_size_in != 2'b10) || (req_addr_in[1:0] != 2'b00);
  assign w_load_data  = mem_rd_data_in;
  assign w_merge_data = mem_rd_data_in;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                              w_next = S_RESP;
          else if (req_we_in && req_size_in == 2'b10) w_next = S_WR;
          else                                        w_next = S_RD;
        end
      end
      S_RD:    w_next = S_CAP;
      S_CAP:   w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_mem_addr   <= IDLE_ADDR;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_mem_we     <= (w_next == S_WR);
      r_resp_valid <= (r_state == S_RESP);
      r_resp_err   <= (r_state == S_RESP) && r_err;
      // Rejected requests never drive a real address onto the memory port.
      if (w_accept) begin
        r_we         <= req_we_in;
        r_err        <= w_req_err;
        r_resp_rdata <= '0;
        r_mem_addr   <= w_req_err ? IDLE_ADDR : {req_addr_in[31:2], 2'b00};
        if (req_we_in && !w_req_err) r_mem_wdata <= req_wdata_in;
      end else if (w_next == S_RESP || w_next == S_IDLE) begin
        r_mem_addr <= IDLE_ADDR;
      end
      if (r_state == S_CAP) begin
        if (r_we) r_mem_wdata  <= w_merge_data;
        else      r_resp_rdata <= w_load_data;
      end
    end
  end

  assign resp_valid_out  = r_resp_valid;
  assign resp_rdata_out  = r_resp_rdata;
  assign resp_err_out    = r_resp_err;
  assign mem_addr_out    = r_mem_addr;
  assign mem_wr_data_out = r_mem_wdata;
  assign mem_we_out      = r_mem_we;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit against a byte-level reference memory
module tb_mem_access_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [1:0]  req_size_in;
  logic        req_unsigned_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic        resp_err_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wr_data_out;
  logic        mem_we_out;
  logic [31:0] mem_rd_data_in;
  logic        mem_init;

  logic [31:0] dmem    [16];
  logic [31:0] ref_mem [16];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk_in = ~clk_in;

  mem_access_unit dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .req_we_in       (req_we_in),
    .req_size_in     (req_size_in),
    .req_unsigned_in (req_unsigned_in),
    .req_addr_in     (req_addr_in),
    .req_wdata_in    (req_wdata_in),
    .resp_valid_out  (resp_valid_out),
    .resp_rdata_out  (resp_rdata_out),
    .resp_err_out    (resp_err_out),
    .mem_addr_out    (mem_addr_out),
    .mem_wr_data_out (mem_wr_data_out),
    .mem_we_out      (mem_we_out),
    .mem_rd_data_in  (mem_rd_data_in)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'h1357_9BDF * (i + 1)) ^ 32'h0F0F_1234;
  endfunction

  // Memory controller stand-in: one-cycle read latency, write on strobe.
  always @(posedge clk_in) begin
    mem_rd_data_in <= dmem[mem_addr_out[5:2]];
    if (mem_init) begin
      for (int i = 0; i < 16; i++) dmem[i] <= init_word(i);
    end else if (mem_we_out) begin
      dmem[mem_addr_out[5:2]] <= mem_wr_data_out;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic illegal(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_SUBWORD_EN
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`else
    return (size != 2'd2) || (addr[1:0] != 2'd0);
`endif
  endfunction

  // Called at a negedge; leaves the bench at the negedge where the response is seen.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
    logic        bad;
    int          lat;
    int          sh;
    int          we_cnt;
    logic [3:0]  idx;
    logic [31:0] old, exp_rdata, exp_wdata, we_addr, we_data;
    bad       = illegal(size, addr);
    idx       = addr[5:2];
    sh        = 8 * int'(addr[1:0]);
    old       = ref_mem[idx];
    exp_rdata = 32'h0;
    exp_wdata = old;
    if (!bad && !we) begin
      case (size)
        2'd0: begin
          exp_rdata = (old >> sh) & 32'hFF;
          if (!uns && exp_rdata >= 32'h80) exp_rdata = exp_rdata - 32'h100;
        end
        2'd1: begin
          exp_rdata = (old >> sh) & 32'hFFFF;
          if (!uns && exp_rdata >= 32'h8000) exp_rdata = exp_rdata - 32'h10000;
        end
        default: exp_rdata = old;
      endcase
    end else if (!bad && we) begin
      case (size)
        2'd0:    exp_wdata = (old & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
        2'd1:    exp_wdata = (old & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
        default: exp_wdata = wdata;
      endcase
    end
    lat = bad ? 1 : (!we ? 3 : (size == 2'd2 ? 2 : 4));

    req_valid_in    = 1'b1;
    req_we_in       = we;
    req_size_in     = size;
    req_unsigned_in = uns;
    req_addr_in     = addr;
    req_wdata_in    = wdata;
    check_eq("ready_idle", 32'(req_ready_out), 32'd1);
    @(posedge clk_in);
    we_cnt  = 0;
    we_addr = 32'h0;
    we_data = 32'h0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk_in);
      check_eq("resp_valid", 32'(resp_valid_out), 32'(k == lat));
      check_eq("ready", 32'(req_ready_out), 32'(k == lat));
      if (mem_we_out) begin
        we_cnt++;
        we_addr = mem_addr_out;
        we_data = mem_wr_data_out;
      end
      if (bad) check_eq("err_addr_idle", mem_addr_out, 32'h0);
      if (k == lat) begin
        check_eq("resp_err", 32'(resp_err_out), 32'(bad));
        check_eq("resp_rdata", resp_rdata_out, exp_rdata);
        req_valid_in = 1'b0;
      end else begin
        req_valid_in    = hold ? 1'b1 : 1'($urandom);
        req_we_in       = 1'($urandom);
        req_size_in     = 2'($urandom);
        req_unsigned_in = 1'($urandom);
        req_addr_in     = $urandom;
        req_wdata_in    = $urandom;
      end
    end
    check_eq("we_count", 32'(we_cnt), 32'((we && !bad) ? 1 : 0));
    if (we && !bad) begin
      check_eq("we_addr", we_addr, {addr[31:2], 2'b00});
      check_eq("we_data", we_data, exp_wdata);
      ref_mem[idx] = exp_wdata;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic        r_we_t;
    logic [1:0]  r_size_t;
    logic [31:0] r_addr_t;
    rst_in          = 1'b1;
    mem_init        = 1'b1;
    req_valid_in    = 1'b0;
    req_we_in       = 1'b0;
    req_size_in     = 2'd0;
    req_unsigned_in = 1'b0;
    req_addr_in     = 32'h0;
    req_wdata_in    = 32'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_eq("rst_ready", 32'(req_ready_out), 32'd1);
    check_eq("rst_mem_addr", mem_addr_out, 32'h0);
    check_eq("rst_mem_wdata", mem_wr_data_out, 32'h0);
    check_eq("rst_mem_we", 32'(mem_we_out), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid_out), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata_out, 32'h0);
    check_eq("rst_resp_err", 32'(resp_err_out), 32'd0);
    rst_in   = 1'b0;
    mem_init = 1'b0;
    @(negedge clk_in);

    run_req(1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEADBEEF, 1'b0);
    run_req(1'b1, 2'd2, 1'b0, 32'h1004, 32'h80FF0000, 1'b0);
    run_req(1'b0, 2'd0, 1'b0, 32'h1007, 32'h0, 1'b0);
    run_req(1'b0, 2'd0, 1'b1, 32'h1007, 32'h0, 1'b0);
    run_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'hAABBCCDD, 1'b0);
    run_req(1'b1, 2'd1, 1'b0, 32'h1002, 32'h00001234, 1'b0);
    run_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b0);
    run_req(1'b1, 2'd2, 1'b0, 32'h1001, 32'h55, 1'b0);
    run_req(1'b0, 2'd3, 1'b0, 32'h1008, 32'h0, 1'b0);
    run_req(1'b1, 2'd2, 1'b0, 32'h100C, 32'hCAFEF00D, 1'b1);
    run_req(1'b0, 2'd2, 1'b0, 32'h100C, 32'h0, 1'b1);
    run_req(1'b1, 2'd0, 1'b0, 32'h1009, 32'h000000A5, 1'b1);
    run_req(1'b0, 2'd0, 1'b1, 32'h1009, 32'h0, 1'b1);

`ifdef LSU_SUBWORD_EN
    r_we_t = 1'b1; r_size_t = 2'd0; r_addr_t = 32'h1005;
`else
    r_we_t = 1'b0; r_size_t = 2'd2; r_addr_t = 32'h1008;
`endif
    req_valid_in = 1'b1;
    req_we_in    = r_we_t;
    req_size_in  = r_size_t;
    req_addr_in  = r_addr_t;
    req_wdata_in = 32'h0000_0077;
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_eq("midrst_ready", 32'(req_ready_out), 32'd1);
    check_eq("midrst_mem_we", 32'(mem_we_out), 32'd0);
    check_eq("midrst_resp_valid", 32'(resp_valid_out), 32'd0);
    check_eq("midrst_mem_addr", mem_addr_out, 32'h0);
    check_eq("midrst_mem_wdata", mem_wr_data_out, 32'h0);
    rst_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check_eq("post_rst_we", 32'(mem_we_out), 32'd0);
      check_eq("post_rst_resp", 32'(resp_valid_out), 32'd0);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = 32'h1000 + ({28'h0, 4'($urandom)} << 2);
      if ($urandom_range(0, 2) == 0) a = a + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) @(negedge clk_in);
      run_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, 1'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      run_req(1'b0, 2'd2, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
